// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction memory read port, redirect input and decode valid/ready handshake.
// master = fetch unit side, slave = memory/decode/branch side.
interface instruction_fetch_unit_if;
    logic        readEnable;
    logic [31:0] address;
    logic [31:0] instruction;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instrOut;
    logic [31:0] instrPc;
    logic        instrFault;

    modport master (
        output readEnable, address, instrValid, instrOut, instrPc, instrFault,
        input  instruction, redirectValid, redirectPc, instrReady
    );

    modport slave (
        input  readEnable, address, instrValid, instrOut, instrPc, instrFault,
        output instruction, redirectValid, redirectPc, instrReady
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC sequencing, 1-cycle-latency memory reads, FIFO buffering toward decode.
// Optional fetch-window check enabled by defining FETCH_RANGE_CHECK_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0100_0000,
    parameter logic [31:0] NOP_INSTRUCTION = 32'h1111_1111,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter logic [31:0] MEM_BASE        = 32'h0100_0000,
    parameter int unsigned MEM_BYTES       = 4096
) (
    input  logic                        clk,
    input  logic                        resetN,
    instruction_fetch_unit_if.master    bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic        fault;
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    logic [31:0] pc_q, pc_d, addr_q, addr_d, resp_addr_q, resp_addr_d;
    logic        re_q, re_d, resp_q, resp_d;
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    entry_t      fifo_q [FIFO_DEPTH];
    logic        valid_q, valid_d, hfault_q, hfault_d;
    logic [31:0] out_q, out_d, hpc_q, hpc_d;

    logic        push_c, pop_c, fault_c;
    logic [SUM_W-1:0] credit_c;
    logic [31:0] redir_pc_c;
    entry_t      entry_c, head_c;

`ifdef FETCH_RANGE_CHECK_EN
    // Unsigned offset wraps for addresses below the base, so one compare covers both bounds.
    logic [31:0] win_off_c;
    assign win_off_c = resp_addr_q - MEM_BASE;
    assign fault_c   = (win_off_c >= MEM_BYTES);
`else
    assign fault_c   = 1'b0;
`endif

    always_comb begin
        pop_c         = valid_q & bus.instrReady;
        push_c        = resp_q & ~bus.redirectValid;
        entry_c.fault = fault_c;
        entry_c.pc    = resp_addr_q;
        entry_c.data  = fault_c ? NOP_INSTRUCTION : bus.instruction;
        credit_c      = SUM_W'(cnt_q) + SUM_W'(resp_q) + SUM_W'(re_q);
        redir_pc_c    = bus.redirectPc & ~32'd3;

        pc_d        = pc_q;
        re_d        = 1'b0;
        addr_d      = addr_q;
        resp_d      = re_q;
        resp_addr_d = addr_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;

        if (bus.redirectValid) begin
            // Flush and issue the redirect target immediately; in-flight response is dropped.
            re_d   = 1'b1;
            addr_d = redir_pc_c;
            pc_d   = redir_pc_c + 32'd4;
            resp_d = 1'b0;
            rd_d   = '0;
            wr_d   = '0;
            cnt_d  = '0;
        end else begin
            if (credit_c < SUM_W'(FIFO_DEPTH)) begin
                re_d   = 1'b1;
                addr_d = pc_q;
                pc_d   = pc_q + 32'd4;
            end
            rd_d  = rd_q + PTR_W'(pop_c);
            wr_d  = wr_q + PTR_W'(push_c);
            cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end

        // Bypass the entry being written when it becomes the new head.
        head_c   = (push_c && (wr_q == rd_d)) ? entry_c : fifo_q[rd_d];
        valid_d  = (cnt_d != '0);
        out_d    = NOP_INSTRUCTION;
        hpc_d    = hpc_q;
        hfault_d = 1'b0;
        if (valid_d) begin
            out_d    = head_c.data;
            hpc_d    = head_c.pc;
            hfault_d = head_c.fault;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pc_q        <= RESET_PC;
            re_q        <= 1'b0;
            addr_q      <= '0;
            resp_q      <= 1'b0;
            resp_addr_q <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            out_q       <= NOP_INSTRUCTION;
            hpc_q       <= '0;
            hfault_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            pc_q        <= pc_d;
            re_q        <= re_d;
            addr_q      <= addr_d;
            resp_q      <= resp_d;
            resp_addr_q <= resp_addr_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            out_q       <= out_d;
            hpc_q       <= hpc_d;
            hfault_q    <= hfault_d;
            if (push_c) fifo_q[wr_q] <= entry_c;
        end
    end

    assign bus.readEnable = re_q;
    assign bus.address    = addr_q;
    assign bus.instrValid = valid_q;
    assign bus.instrOut   = out_q;
    assign bus.instrPc    = hpc_q;
    assign bus.instrFault = hfault_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!resetN)
        !(push_c && (cnt_q == CNT_W'(FIFO_DEPTH))));

    a_params_ok: assert property (@(posedge clk)
        (FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0) &&
        (MEM_BYTES != 0) && (MEM_BASE[1:0] == 2'b00));
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: memory model returns address-tagged words.
module tb_instruction_fetch_unit;
    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam logic [31:0] NOP  = 32'h1111_1111;

    logic clk = 1'b0;
    logic resetN;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic exp_fault(input logic [31:0] a);
`ifdef FETCH_RANGE_CHECK_EN
        return (a < BASE) || (a >= BASE + 32'd4096);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return exp_fault(a) ? NOP : tag(a);
    endfunction

    // One-cycle-latency instruction memory
    always @(posedge clk) bus.instruction <= bus.readEnable ? tag(bus.address) : 32'h0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_head(input string name, input logic [31:0] pc);
        check({name, "_valid"}, 32'(bus.instrValid), 32'd1);
        check({name, "_pc"},    bus.instrPc, pc);
        check({name, "_out"},   bus.instrOut, exp_word(pc));
        check({name, "_fault"}, 32'(bus.instrFault), 32'(exp_fault(pc)));
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        bus.redirectValid = 1'b1;
        bus.redirectPc    = pc;
        step();
        bus.redirectValid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        resetN            = 1'b0;
        bus.instrReady    = 1'b1;
        bus.redirectValid = 1'b0;
        bus.redirectPc    = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_re",    32'(bus.readEnable), 32'd0);
        check("rst_addr",  bus.address, 32'h0);
        check("rst_valid", 32'(bus.instrValid), 32'd0);
        check("rst_out",   bus.instrOut, NOP);
        check("rst_pc",    bus.instrPc, 32'h0);
        check("rst_fault", 32'(bus.instrFault), 32'd0);

        resetN = 1'b1;
        step();
        check("c1_re",    32'(bus.readEnable), 32'd1);
        check("c1_addr",  bus.address, BASE);
        check("c1_valid", 32'(bus.instrValid), 32'd0);
        step();
        check("c2_addr",  bus.address, BASE + 32'd4);
        check("c2_valid", 32'(bus.instrValid), 32'd0);
        step();
        expect_head("c3", BASE);
        step();
        expect_head("c4", BASE + 32'd4);
        step();
        expect_head("c5", BASE + 32'd8);

        // Backpressure: four entries buffered, fetch stops, nothing lost on release
        bus.instrReady = 1'b0;
        repeat (10) step();
        check("stall_re", 32'(bus.readEnable), 32'd0);
        expect_head("stall", BASE + 32'd8);
        bus.instrReady = 1'b1;
        step();
        check("nocredit_re", 32'(bus.readEnable), 32'd0);
        expect_head("drain0", BASE + 32'd12);
        for (int i = 1; i <= 4; i++) begin
            step();
            expect_head("drain", BASE + 32'd12 + 32'(4 * i));
        end
        check("inflight_re",   32'(bus.readEnable), 32'd1);
        check("inflight_addr", bus.address, BASE + 32'd36);

        // Redirect with two reads in flight
        redirect_to(BASE + 32'h103);
        check("rd1_re",    32'(bus.readEnable), 32'd1);
        check("rd1_addr",  bus.address, BASE + 32'h100);
        check("rd1_valid", 32'(bus.instrValid), 32'd0);
        step();
        check("rd2_addr",  bus.address, BASE + 32'h104);
        check("rd2_valid", 32'(bus.instrValid), 32'd0);
        step();
        expect_head("rd3", BASE + 32'h100);
        step();
        expect_head("rd4", BASE + 32'h104);

        // Redirect coinciding with a handshake on a full FIFO
        bus.instrReady = 1'b0;
        repeat (6) step();
        expect_head("preflush", BASE + 32'h104);
        bus.instrReady = 1'b1;
        redirect_to(BASE + 32'h200);
        check("hs1_valid", 32'(bus.instrValid), 32'd0);
        check("hs1_addr",  bus.address, BASE + 32'h200);
        step();
        check("hs2_valid", 32'(bus.instrValid), 32'd0);
        step();
        expect_head("hs3", BASE + 32'h200);
        step();
        expect_head("hs4", BASE + 32'h204);

        // Back-to-back redirects: the last one wins
        bus.redirectValid = 1'b1;
        bus.redirectPc    = BASE + 32'h300;
        step();
        check("bb1_addr", bus.address, BASE + 32'h300);
        bus.redirectPc = BASE + 32'h400;
        step();
        bus.redirectValid = 1'b0;
        check("bb2_addr",  bus.address, BASE + 32'h400);
        check("bb2_valid", 32'(bus.instrValid), 32'd0);
        step();
        check("bb3_valid", 32'(bus.instrValid), 32'd0);
        step();
        expect_head("bb4", BASE + 32'h400);
        step();
        expect_head("bb5", BASE + 32'h404);

        // PC wrap at the top of the address space
        redirect_to(32'hFFFF_FFF8);
        step();
        step();
        expect_head("wrap0", 32'hFFFF_FFF8);
        step();
        expect_head("wrap1", 32'hFFFF_FFFC);
        step();
        expect_head("wrap2", 32'h0000_0000);

        // Crossing the end of the fetch window
        redirect_to(BASE + 32'hFFC);
        step();
        step();
        expect_head("win_last", BASE + 32'hFFC);
        step();
        expect_head("win_out", BASE + 32'h1000);

        // Reset with three entries buffered
        bus.instrReady = 1'b0;
        redirect_to(BASE + 32'h500);
        repeat (4) step();
        check("pre_rst_re", 32'(bus.readEnable), 32'd0);
        expect_head("pre_rst", BASE + 32'h500);
        resetN = 1'b0;
        #1;
        check("mrst_valid", 32'(bus.instrValid), 32'd0);
        check("mrst_re",    32'(bus.readEnable), 32'd0);
        check("mrst_addr",  bus.address, 32'h0);
        check("mrst_out",   bus.instrOut, NOP);
        check("mrst_pc",    bus.instrPc, 32'h0);
        @(negedge clk);
        bus.instrReady = 1'b1;
        resetN         = 1'b1;
        step();
        check("restart_re",   32'(bus.readEnable), 32'd1);
        check("restart_addr", bus.address, BASE);
        step();
        step();
        expect_head("restart", BASE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
